mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the instruction-fetch requester and the load/store requester of the RV32 core.
- Requesters are the PC/instruction path (IF) and the ALU-address/MMU path (D). The memory side is a single req/ack port to the unified memory.
- Contains a three-state FSM with round-robin tie-break, registered request/response paths and an acknowledge timeout that reports an error.

---
 rtl/arb_pkg.sv | 6 +
 rtl/arb_timeout.sv | 25 ++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
   typedef enum logic {REQ_IF, REQ_D} req_id_t;
   localparam int CNT_W = 8;
endpackage

// File: rtl/arb_timeout.sv
// Acknowledge-wait counter; expired flags count==limit combinationally.
module arb_timeout
   import arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = (r_cnt == limit);
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be within 1..255");
   end

   // The counter holds k-1 on the k-th BUSY cycle, so the limit is one less.
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   arb_state_t        r_state, w_state_nxt;
   req_id_t           r_gnt, w_gnt_nxt;
   req_id_t           r_last, w_last_nxt;
   logic              r_m_req, w_m_req_nxt;
   logic              r_m_we, w_m_we_nxt;
   logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
   logic [DATA_W-1:0] r_m_wdata, w_m_wdata_nxt;
   logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
   logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
   logic              r_if_done, w_if_done_nxt;
   logic              r_d_done, w_d_done_nxt;
   logic              r_err, w_err_nxt;
   logic              w_clr, w_en, w_expired, w_pick_d;

   arb_timeout u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .en      (w_en),
      .limit   (LIMIT),
      .expired (w_expired)
   );

   assign w_pick_d = d_req & (~if_req | (r_last == REQ_IF));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= REQ_IF;
         r_last     <= REQ_IF;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_if_done  <= 1'b0;
         r_d_done   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_last     <= w_last_nxt;
         r_m_req    <= w_m_req_nxt;
         r_m_we     <= w_m_we_nxt;
         r_m_addr   <= w_m_addr_nxt;
         r_m_wdata  <= w_m_wdata_nxt;
         r_if_rdata <= w_if_rdata_nxt;
         r_d_rdata  <= w_d_rdata_nxt;
         r_if_done  <= w_if_done_nxt;
         r_d_done   <= w_d_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_last_nxt     = r_last;
      w_m_req_nxt    = r_m_req;
      w_m_we_nxt     = r_m_we;
      w_m_addr_nxt   = r_m_addr;
      w_m_wdata_nxt  = r_m_wdata;
      w_if_rdata_nxt = r_if_rdata;
      w_d_rdata_nxt  = r_d_rdata;
      w_if_done_nxt  = 1'b0;
      w_d_done_nxt   = 1'b0;
      w_err_nxt      = 1'b0;
      w_clr          = 1'b0;
      w_en           = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (if_req || d_req) begin
               w_state_nxt = BUSY;
               w_m_req_nxt = 1'b1;
               w_clr       = 1'b1;
               if (w_pick_d) begin
                  w_gnt_nxt     = REQ_D;
                  w_last_nxt    = REQ_D;
                  w_m_we_nxt    = d_we;
                  w_m_addr_nxt  = d_addr;
                  w_m_wdata_nxt = d_wdata;
               end else begin
                  w_gnt_nxt    = REQ_IF;
                  w_last_nxt   = REQ_IF;
                  w_m_we_nxt   = 1'b0;
                  w_m_addr_nxt = if_addr;
               end
            end
         end
         BUSY: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (m_ack || w_expired) begin
               w_state_nxt = RESP;
               w_m_req_nxt = 1'b0;
               w_err_nxt   = ~m_ack;
               if (r_gnt == REQ_D) begin
                  w_d_done_nxt  = 1'b1;
                  w_d_rdata_nxt = m_ack ? m_rdata : '0;
               end else begin
                  w_if_done_nxt  = 1'b1;
                  w_if_rdata_nxt = m_ack ? m_rdata : '0;
               end
            end else begin
               w_en = 1'b1;
            end
         end
         RESP: begin
            w_m_we_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign m_req    = r_m_req;
   assign m_we     = r_m_we;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;
   assign if_done  = r_if_done;
   assign d_done   = r_d_done;
   assign err      = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;
   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  mcyc;
   } txn_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
   logic        if_done, d_done, err, m_req, m_we;
   logic        m_ack = 0;
   logic [31:0] m_rdata = 0;

   int   vectors = 0, miscompares = 0;
   int   cyc = 0, bcnt = 0, last_cyc = 0, unstable = 0, dual = 0;
   int   ack_at = 1, d_more = 0, if_more = 0;
   logic rd_ovr_en = 0;
   logic [31:0] rd_ovr = 0;
   logic        g_we;
   logic [31:0] g_addr, g_wdata;
   txn_t exp_q[$], obs_q[$];

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .err(err), .m_req(m_req), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic txn_t mk(input logic d, input logic we,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic e,
                               input int mc);
      txn_t t;
      t.is_d = d; t.we = we; t.addr = a; t.wdata = wd;
      t.rdata = rd; t.err = e; t.mcyc = 8'(mc);
      return t;
   endfunction

   task automatic tick();
      txn_t o;
      @(negedge clk);
      cyc++;
      if (m_req) begin
         bcnt++;
         if (bcnt == 1) begin
            g_we = m_we; g_addr = m_addr;
            g_wdata = m_we ? m_wdata : 32'h0;
         end else if (m_addr !== g_addr || m_we !== g_we) begin
            unstable++;
         end
         m_ack = (ack_at != 0) && (bcnt == ack_at);
         m_rdata = !m_ack ? 32'hBAD0_BAD0 :
                   rd_ovr_en ? rd_ovr : mem_fn(m_addr);
      end else begin
         if (bcnt != 0) last_cyc = bcnt;
         bcnt = 0; m_ack = 0; m_rdata = 32'hBAD0_BAD0;
      end
      if (if_done || d_done) begin
         if (if_done && d_done) dual++;
         o = mk(d_done, g_we, g_addr, g_wdata,
                d_done ? d_rdata : if_rdata, err, last_cyc);
         obs_q.push_back(o);
         if (d_done) begin
            if (d_more > 0) begin d_more--; d_addr += 4; end
            else d_req = 0;
         end else begin
            if (if_more > 0) begin if_more--; if_addr += 4; end
            else if_req = 0;
         end
      end
   endtask

   task automatic collect(input int n, input string nm);
      int k = 0;
      while (obs_q.size() < n && k < 200) begin tick(); k++; end
      if (obs_q.size() < n) begin
         vectors++; miscompares++;
         $display("FAIL %s no done pulse: got %0d txns, need %0d",
                  nm, obs_q.size(), n);
      end
   endtask

   task automatic do_reset();
      rst_n = 0; if_req = 0; d_req = 0; d_we = 0;
      m_ack = 0; ack_at = 1; rd_ovr_en = 0; d_more = 0; if_more = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      bcnt = 0; exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 0;
      #1;
      vectors++;
      if ({m_req, m_we, m_addr, m_wdata, if_rdata, d_rdata,
           if_done, d_done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_async outputs not zero m_req=%b m_addr=%h", m_req, m_addr);
      end
      do_reset();
      tick();
      vectors++;
      if ({m_req, m_we, m_addr, m_wdata, if_rdata, d_rdata,
           if_done, d_done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_idle outputs not zero m_req=%b m_addr=%h", m_req, m_addr);
      end
   endtask

   task automatic test_single_fetch();
      txn_t e, o;
      int t0;
      do_reset();
      rd_ovr_en = 1; rd_ovr = 32'h0050_0093; ack_at = 1;
      if_addr = 32'h10; if_req = 1;
      exp_q.push_back(mk(0, 0, 32'h10, 0, 32'h0050_0093, 0, 1));
      t0 = cyc;
      collect(1, "fetch");
      vectors++;
      if (cyc - t0 != 2) begin
         miscompares++;
         $display("FAIL fetch_latency got %0d need 2", cyc - t0);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL fetch_txn got %h need %h", o, e);
         end
      end
      tick();
      vectors++;
      if ({if_done, d_done, err} !== 3'b000 || if_rdata !== 32'h0050_0093) begin
         miscompares++;
         $display("FAIL fetch_pulse done/err=%b%b%b rdata=%h need 000 00500093",
                  if_done, d_done, err, if_rdata);
      end
      rd_ovr_en = 0;
   endtask

   task automatic test_tie_after_reset();
      txn_t e, o;
      do_reset();
      d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; if_addr = 32'h20;
      d_req = 1; if_req = 1;
      exp_q.push_back(mk(1, 1, 32'h100, 32'hDEAD_BEEF, mem_fn(32'h100), 0, 1));
      exp_q.push_back(mk(0, 0, 32'h20, 0, mem_fn(32'h20), 0, 1));
      collect(2, "tie12");
      d_we = 0; d_addr = 32'h104; if_addr = 32'h24;
      d_req = 1; if_req = 1;
      exp_q.push_back(mk(1, 0, 32'h104, 0, mem_fn(32'h104), 0, 1));
      exp_q.push_back(mk(0, 0, 32'h24, 0, mem_fn(32'h24), 0, 1));
      collect(4, "tie34");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL tie_txn got %h need %h", o, e);
         end
      end
   endtask

   task automatic test_contention();
      txn_t e, o;
      do_reset();
      ack_at = 2; unstable = 0; dual = 0;
      d_we = 0; d_addr = 32'h300; if_addr = 32'h400;
      d_more = 2; if_more = 2; d_req = 1; if_req = 1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(1, 0, 32'h300 + 4 * i, 0, mem_fn(32'h300 + 4 * i), 0, 2));
         exp_q.push_back(mk(0, 0, 32'h400 + 4 * i, 0, mem_fn(32'h400 + 4 * i), 0, 2));
      end
      collect(6, "contention");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL contention_txn got %h need %h", o, e);
         end
      end
      vectors++;
      if (unstable != 0 || dual != 0) begin
         miscompares++;
         $display("FAIL contention_stable unstable=%0d dual=%0d need 0 0", unstable, dual);
      end
   endtask

   task automatic test_timeout();
      txn_t e, o;
      ack_at = 0; unstable = 0;
      d_we = 0; d_addr = 32'h200; d_wdata = 32'h5555_AAAA; d_req = 1;
      exp_q.push_back(mk(1, 0, 32'h200, 0, 32'h0, 1, 15));
      repeat (4) tick();
      d_addr = 32'h999; d_we = 1;
      collect(1, "timeout");
      ack_at = 1;
      if_addr = 32'h44; if_req = 1;
      exp_q.push_back(mk(0, 0, 32'h44, 0, mem_fn(32'h44), 0, 1));
      collect(2, "after_timeout");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL timeout_txn got %h need %h", o, e);
         end
      end
      vectors++;
      if (unstable != 0 || d_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL timeout_hold unstable=%0d d_rdata=%h need 0 0", unstable, d_rdata);
      end
      d_we = 0;
   endtask

   task automatic test_ack_at_limit();
      txn_t e, o;
      ack_at = 15; rd_ovr_en = 1; rd_ovr = 32'h1234_5678;
      d_we = 0; d_addr = 32'h208; d_req = 1;
      exp_q.push_back(mk(1, 0, 32'h208, 0, 32'h1234_5678, 0, 15));
      collect(1, "ack_limit");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ack_limit_txn got %h need %h", o, e);
         end
      end
      rd_ovr_en = 0; ack_at = 1;
   endtask

   task automatic test_reset_mid_access();
      txn_t e, o;
      ack_at = 0;
      d_we = 1; d_addr = 32'h500; d_wdata = 32'h0BAD_F00D; d_req = 1;
      repeat (4) tick();
      vectors++;
      if (m_req !== 1'b1 || m_addr !== 32'h500) begin
         miscompares++;
         $display("FAIL mid_busy m_req=%b m_addr=%h need 1 00000500", m_req, m_addr);
      end
      #2 rst_n = 0;
      #1;
      vectors++;
      if ({m_req, m_we, m_addr, m_wdata, if_rdata, d_rdata,
           if_done, d_done, err} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset outputs m_req=%b m_addr=%h need all 0", m_req, m_addr);
      end
      d_req = 0; ack_at = 1;
      repeat (2) tick();
      rst_n = 1;
      repeat (3) tick();
      vectors++;
      if (obs_q.size() != 0) begin
         miscompares++;
         $display("FAIL mid_no_done got %0d done pulses need 0", obs_q.size());
      end
      obs_q.delete();
      d_we = 0; d_addr = 32'h600; if_addr = 32'h700; d_req = 1; if_req = 1;
      exp_q.push_back(mk(1, 0, 32'h600, 0, mem_fn(32'h600), 0, 1));
      exp_q.push_back(mk(0, 0, 32'h700, 0, mem_fn(32'h700), 0, 1));
      collect(2, "post_reset_tie");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset_txn got %h need %h", o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_tie_after_reset();
      test_contention();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_access();
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
